// File: rtl/hpdl_pkg.sv
// Shared constants and state encoding for the HPDL display write scheduler.
package hpdl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } hpdl_state_e;

  localparam int unsigned DISPLAY_LENGTH = 16;
  localparam logic [6:0]  SPACE          = 7'h20;
  localparam logic [6:0]  CARET          = 7'h5F;

endpackage

// File: rtl/hpdl_rr_pick.sv
// Round-robin picker: first set request bit searching upward (with wrap) from ptr+1.
module hpdl_rr_pick
  import hpdl_pkg::*;
(
  input  logic [15:0] req,
  input  logic [3:0]  ptr,
  output logic [3:0]  grant,
  output logic        valid
);

  logic [3:0] idx;

  // Scan from the farthest offset to the nearest so the nearest set bit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = |req;
    for (int unsigned k = 0; k < DISPLAY_LENGTH; k++) begin
      idx = ptr + 4'(DISPLAY_LENGTH - k);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/hpdl_write_scheduler.sv
// Refreshes dirty places of four HPDL-1414 devices with timed setup/strobe/hold bus cycles.
module hpdl_write_scheduler
  import hpdl_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 16,
  parameter int unsigned BLINK_LOG2   = 22
) (
  input  logic       CLK_i,
  input  logic       RST_N_i,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [3:0] i_wr_pos,
  input  logic [6:0] i_wr_char,
  input  logic       i_clear,
  input  logic       i_caret_en,
  input  logic [3:0] i_caret_pos,
  output logic [6:0] HPDL_D,
  output logic [1:0] HPDL_A,
  output logic [3:0] HPDL_WR,
  output logic       o_busy
);

  localparam int unsigned CW      = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYCLES - 1);

  hpdl_state_e           state_q, state_d;
  logic [CW-1:0]         ph_cnt_q;
  logic [6:0]            char_q [DISPLAY_LENGTH];
  logic [15:0]           dirty_q, set_mask, clr_mask, dirty_pick;
  logic [3:0]            ptr_q, place_q, grant;
  logic                  pick_valid, touched_q, start, ph_done, hold_exit;
  logic [BLINK_LOG2-1:0] blink_cnt_q;
  logic                  blink_on_q, blink_wrap;
  logic [3:0]            caret_pos_q;
  logic                  caret_en_q, caret_chg, wr_accept;
  logic [3:0]            wr_n_d;
  logic [6:0]            code;

  assign o_wr_ready = RST_N_i & ~i_clear;
  assign wr_accept  = i_wr_valid & o_wr_ready;
  assign blink_wrap = &blink_cnt_q;
  assign caret_chg  = (i_caret_pos != caret_pos_q) | (i_caret_en != caret_en_q);
  assign ph_done    = (ph_cnt_q == PH_LAST);
  assign hold_exit  = (state_q == ST_HOLD) & ph_done;
  assign o_busy     = (state_q != ST_IDLE) | (|dirty_q);

  always_comb begin
    set_mask = '0;
    if (i_clear) set_mask = '1;
    if (wr_accept) set_mask[i_wr_pos] = 1'b1;
    if (blink_wrap && i_caret_en) set_mask[i_caret_pos] = 1'b1;
    if (caret_chg) begin
      set_mask[caret_pos_q] = 1'b1;
      set_mask[i_caret_pos] = 1'b1;
    end
  end

  // The serviced bit is dropped before picking so the next place is chosen on the exit edge.
  always_comb begin
    clr_mask = '0;
    if (hold_exit && !touched_q) clr_mask[place_q] = 1'b1;
    dirty_pick = dirty_q & ~clr_mask;
  end

  hpdl_rr_pick u_pick (
    .req   (dirty_pick),
    .ptr   (ptr_q),
    .grant (grant),
    .valid (pick_valid)
  );

  assign code = (i_caret_en && (grant == i_caret_pos) && blink_on_q) ? CARET : char_q[grant];

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (pick_valid) begin state_d = ST_SETUP; start = 1'b1; end
      ST_SETUP:  if (ph_done) state_d = ST_STROBE;
      ST_STROBE: if (ph_done) state_d = ST_HOLD;
      ST_HOLD:
        if (ph_done) begin
          if (pick_valid) begin state_d = ST_SETUP; start = 1'b1; end
          else state_d = ST_IDLE;
        end
      default:   state_d = ST_IDLE;
    endcase
    wr_n_d = '1;
    if (state_d == ST_STROBE) wr_n_d[place_q[3:2]] = 1'b0;
  end

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      state_q     <= ST_IDLE;
      ph_cnt_q    <= '0;
      HPDL_WR     <= '1;
      HPDL_D      <= '0;
      HPDL_A      <= '0;
      for (int unsigned i = 0; i < DISPLAY_LENGTH; i++) char_q[i] <= SPACE;
      dirty_q     <= '1;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      ptr_q       <= 4'hF;
      place_q     <= '0;
      touched_q   <= 1'b0;
      caret_pos_q <= i_caret_pos;
      caret_en_q  <= i_caret_en;
    end else begin
      state_q  <= state_d;
      ph_cnt_q <= (state_d != state_q) ? '0 : ph_cnt_q + CW'(1);
      HPDL_WR  <= wr_n_d;
      if (start) begin
        place_q   <= grant;
        ptr_q     <= grant;
        HPDL_D    <= code;
        HPDL_A    <= ~grant[1:0];
        touched_q <= set_mask[grant];
      end else begin
        touched_q <= touched_q | set_mask[place_q];
      end
      if (i_clear) begin
        for (int unsigned i = 0; i < DISPLAY_LENGTH; i++) char_q[i] <= SPACE;
      end else if (wr_accept) begin
        char_q[i_wr_pos] <= i_wr_char;
      end
      dirty_q     <= dirty_pick | set_mask;
      blink_cnt_q <= blink_cnt_q + BLINK_LOG2'(1);
      if (blink_wrap) blink_on_q <= ~blink_on_q;
      caret_pos_q <= i_caret_pos;
      caret_en_q  <= i_caret_en;
    end
  end

endmodule
